cam_capture: RTL and testbench

Camera capture stage upstream of the display stage. It samples the OV7670 parallel bus in RGB444 mode, assembles byte pairs into 12-bit pixels, and writes them into the 640x480 frame buffer that the display stage reads. The first frames after enable are discarded so camera settings can settle. Writes are bounded so that a malformed frame can never address past pixel 307199.

---
 rtl/cam_capture_pkg.sv | 32 +++
 rtl/cam_capture_sync_edge_det.sv | 23 ++
 rtl/cam_capture.sv | 188 ++++++++++++++++++
 tb/tb_cam_capture.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path and the display stage that
// reads the same frame buffer.
package cam_capture_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned FB_DEPTH = 307200;
  localparam int unsigned FB_LAST  = 307199;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned CNT_W  = 20;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SKIP,
    ST_SYNC_CAP,
    ST_CAPTURE
  } cap_state_t;

  function automatic logic [ADDR_W-1:0] addr_inc_sat(input logic [ADDR_W-1:0] a,
                                                     input logic [ADDR_W-1:0] last);
    return (a >= last) ? last : a + 1'b1;
  endfunction

endpackage

// File: rtl/cam_capture_sync_edge_det.sv
// One-flop delay of a level input with single-cycle rise/fall pulses derived
// from the live input against its registered copy.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_q <= 1'b0;
    else         r_q <= i_d;
  end

  assign o_q    = r_q;
  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/cam_capture.sv
// OV7670 RGB444 capture: discards settling frames after enable, then packs
// byte pairs into 12-bit pixels and writes them to the frame buffer.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = cam_capture_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE    = cam_capture_pkg::V_ACTIVE,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic        i_p_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic        o_wr,
  output logic [18:0] o_waddr,
  output logic [11:0] o_wdata,
  output logic        o_sof,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int unsigned PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam logic [CNT_W-1:0]  PIX_TOTAL_C = CNT_W'(PIX_TOTAL);
  localparam logic [ADDR_W-1:0] ADDR_LAST =
    (PIX_TOTAL > FB_DEPTH) ? ADDR_W'(FB_LAST) : ADDR_W'(PIX_TOTAL - 1);
  localparam logic [3:0]  SKIP_N = 4'(SKIP_FRAMES);
  localparam logic [10:0] X_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] Y_LIM  = 11'(V_ACTIVE);

  logic w_vs_q, w_vs_rise, w_vs_fall;
  logic w_hs_q, w_hs_rise, w_hs_fall;
  logic w_unused;

  sync_edge_det u_vs_det (
    .i_clk  (i_p_clk),
    .i_rstn (i_rstn),
    .i_d    (i_vsync),
    .o_q    (w_vs_q),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  sync_edge_det u_hs_det (
    .i_clk  (i_p_clk),
    .i_rstn (i_rstn),
    .i_d    (i_href),
    .o_q    (w_hs_q),
    .o_rise (w_hs_rise),
    .o_fall (w_hs_fall)
  );

  assign w_unused = &{1'b0, w_hs_q, w_hs_rise};

  cap_state_t        r_state;
  logic [3:0]        r_skip_cnt;
  logic              r_phase;
  logic [3:0]        r_red;
  logic [10:0]       r_x;
  logic [10:0]       r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_waddr;
  rgb444_t           r_wdata;
  logic              r_sof;
  logic              r_done;
  logic              r_err;
  logic              r_busy;

  logic             w_accept;
  logic             w_pix;
  logic             w_in_win;
  logic             w_enter_cap;
  logic [CNT_W-1:0] w_pix_cnt_nxt;

  // vs_q is low throughout CAPTURE, so the byte sampled on the vsync rise
  // edge still completes and its write lands alongside o_frame_done.
  assign w_accept    = (r_state == ST_CAPTURE) && i_en && i_href && !w_vs_q;
  assign w_pix       = w_accept && r_phase;
  assign w_in_win    = (r_x < X_LIM) && (r_y < Y_LIM);
  assign w_enter_cap = i_en && w_vs_fall &&
                       ((r_state == ST_SYNC_CAP) ||
                        ((r_state == ST_SYNC) && (SKIP_N == 4'd0)));
  assign w_pix_cnt_nxt = (w_pix && (r_pix_cnt != '1)) ? r_pix_cnt + 1'b1 : r_pix_cnt;

  always_ff @(posedge i_p_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= '0;
      r_phase    <= 1'b0;
      r_red      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_pix_cnt  <= '0;
      r_wr       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_sof      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_sof  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= (r_state == ST_SKIP) || (r_state == ST_CAPTURE);

      if (!i_en) begin
        r_state <= ST_IDLE;
        r_phase <= 1'b0;
      end else if (w_enter_cap) begin
        r_state   <= ST_CAPTURE;
        r_sof     <= 1'b1;
        r_addr    <= '0;
        r_waddr   <= '0;
        r_x       <= '0;
        r_y       <= '0;
        r_pix_cnt <= '0;
        r_phase   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_SYNC;
            r_skip_cnt <= '0;
          end
          ST_SYNC: begin
            if (w_vs_fall) begin
              r_state    <= ST_SKIP;
              r_skip_cnt <= '0;
            end
          end
          ST_SKIP: begin
            if (w_vs_rise) begin
              if (r_skip_cnt == SKIP_N - 4'd1) r_state <= ST_SYNC_CAP;
              else                             r_skip_cnt <= r_skip_cnt + 4'd1;
            end
          end
          ST_SYNC_CAP: begin
            r_state <= ST_SYNC_CAP;
          end
          ST_CAPTURE: begin
            if (!i_href) begin
              r_phase <= 1'b0;
            end else if (w_accept) begin
              r_phase <= ~r_phase;
              if (!r_phase) begin
                r_red <= i_data[3:0];
              end else begin
                if (w_in_win) begin
                  r_wr    <= 1'b1;
                  r_wdata <= '{r: r_red, g: i_data[7:4], b: i_data[3:0]};
                  r_waddr <= r_addr;
                  r_addr  <= addr_inc_sat(r_addr, ADDR_LAST);
                end
                if (r_x != '1) r_x <= r_x + 11'd1;
                r_pix_cnt <= w_pix_cnt_nxt;
              end
            end
            if (w_hs_fall) begin
              r_x <= '0;
              if ((r_x != '0) && (r_y != '1)) r_y <= r_y + 11'd1;
            end
            if (w_vs_rise) begin
              r_done  <= 1'b1;
              r_err   <= (w_pix_cnt_nxt != PIX_TOTAL_C);
              r_state <= ST_SYNC_CAP;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_wr         = r_wr;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_sof        = r_sof;
  assign o_frame_done = r_done;
  assign o_frame_err  = r_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture using a reduced 8x4 frame geometry.
module tb_cam_capture;

  localparam int TB_H = 8;
  localparam int TB_V = 4;

  logic        i_p_clk;
  logic        i_rstn;
  logic        i_en;
  logic        i_vsync;
  logic        i_href;
  logic [7:0]  i_data;
  logic        o_wr;
  logic [18:0] o_waddr;
  logic [11:0] o_wdata;
  logic        o_sof;
  logic        o_frame_done;
  logic        o_frame_err;
  logic        o_busy;

  cam_capture #(
    .H_ACTIVE    (TB_H),
    .V_ACTIVE    (TB_V),
    .SKIP_FRAMES (2)
  ) dut (
    .i_p_clk      (i_p_clk),
    .i_rstn       (i_rstn),
    .i_en         (i_en),
    .i_vsync      (i_vsync),
    .i_href       (i_href),
    .i_data       (i_data),
    .o_wr         (o_wr),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_sof        (o_sof),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  initial i_p_clk = 1'b0;
  always #5 i_p_clk = ~i_p_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_first = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: cumulative counters only written here.
  int wr_cnt = 0, addr_bad = 0, data_bad = 0, done_cnt = 0, sof_cnt = 0;
  int exp_addr = 0;
  logic last_err = 1'b0;
  int m_a, m_l, m_c;
  logic [11:0] m_e;

  always @(negedge i_p_clk) begin
    if (o_sof) begin
      sof_cnt++;
      exp_addr = 0;
    end
    if (o_wr) begin
      wr_cnt++;
      m_a = int'(o_waddr);
      if (m_a != exp_addr) addr_bad++;
      m_l = m_a / TB_H;
      m_c = m_a % TB_H;
      if (m_a == 0) m_e = 12'hABC;
      else          m_e = {4'(m_c), 4'(m_l), ~4'(m_c)};
      if (o_wdata !== m_e) data_bad++;
      exp_addr++;
    end
    if (o_frame_done) begin
      done_cnt++;
      last_err = o_frame_err;
    end
  end

  task automatic send_frame(input int lines, input int ppl, input bit odd,
                            input int en_drop, input int rst_at);
    int pix;
    logic [3:0] cn, ln;
    logic [7:0] b0, b1;
    pix = 0;
    i_vsync = 1'b0;
    repeat (3) @(negedge i_p_clk);
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < ppl; c++) begin
        cn = 4'(c);
        ln = 4'(l);
        if (l == 0 && c == 0) begin
          b0 = 8'h0A; b1 = 8'hBC;
        end else begin
          b0 = {4'h5, cn}; b1 = {ln, ~cn};
        end
        i_href = 1'b1;
        i_data = b0;
        if (pix == rst_at) begin
          check("pre_rst_wr", 64'(o_wr), 64'd1);
          #2 i_rstn = 1'b0;
          #1 check("rst_outs_zero",
                   64'({o_wr, o_waddr, o_wdata, o_sof, o_frame_done, o_frame_err, o_busy}), 64'd0);
          @(negedge i_p_clk);
          i_rstn = 1'b1;
          pix++;
          continue;
        end
        @(negedge i_p_clk);
        if (chk_first && l == 0 && c == 0) check("lat_pre_wr", 64'(o_wr), 64'd0);
        if (pix == en_drop) i_en = 1'b0;
        i_data = b1;
        @(negedge i_p_clk);
        if (chk_first && l == 0 && c == 0) begin
          check("lat_wr", 64'(o_wr), 64'd1);
          check("lat_wdata", 64'(o_wdata), 64'hABC);
          check("lat_waddr", 64'(o_waddr), 64'd0);
        end
        if (pix == en_drop) check("en_off_wr", 64'(o_wr), 64'd0);
        pix++;
      end
      if (odd) begin
        i_data = 8'hFF;
        @(negedge i_p_clk);
      end
      i_href = 1'b0;
      i_data = 8'h00;
      repeat (3) @(negedge i_p_clk);
    end
    i_vsync = 1'b1;
    repeat (4) @(negedge i_p_clk);
  endtask

  task automatic frame_chk(input string tag, input int lines, input int ppl, input bit odd,
                           input int en_drop, input int rst_at, input int exp_wr,
                           input int exp_done, input int exp_err, input int exp_sof);
    int w0, d0, s0, a0, x0;
    w0 = wr_cnt; d0 = done_cnt; s0 = sof_cnt; a0 = addr_bad; x0 = data_bad;
    send_frame(lines, ppl, odd, en_drop, rst_at);
    check($sformatf("%s_writes", tag), 64'(wr_cnt - w0), 64'(exp_wr));
    check($sformatf("%s_done", tag), 64'(done_cnt - d0), 64'(exp_done));
    check($sformatf("%s_sof", tag), 64'(sof_cnt - s0), 64'(exp_sof));
    check($sformatf("%s_addr_seq", tag), 64'(addr_bad - a0), 64'd0);
    check($sformatf("%s_data", tag), 64'(data_bad - x0), 64'd0);
    if (exp_done != 0) check($sformatf("%s_err", tag), 64'(last_err), 64'(exp_err));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rstn  = 1'b1;
    i_en    = 1'b0;
    i_vsync = 1'b1;
    i_href  = 1'b0;
    i_data  = 8'h00;
    #1 i_rstn = 1'b0;
    repeat (3) @(negedge i_p_clk);
    check("reset_outs",
          64'({o_wr, o_waddr, o_wdata, o_sof, o_frame_done, o_frame_err, o_busy}), 64'd0);
    i_rstn = 1'b1;
    @(negedge i_p_clk);
    i_en = 1'b1;
    repeat (3) @(negedge i_p_clk);

    frame_chk("skip1", TB_V, TB_H, 1'b0, -1, -1, 0, 0, 0, 0);
    check("skip_busy", 64'(o_busy), 64'd1);
    frame_chk("skip2", TB_V, TB_H, 1'b0, -1, -1, 0, 0, 0, 0);
    chk_first = 1'b1;
    frame_chk("full", TB_V, TB_H, 1'b0, -1, -1, 32, 1, 0, 1);
    chk_first = 1'b0;
    frame_chk("long_line", TB_V, 12, 1'b0, -1, -1, 32, 1, 1, 1);
    frame_chk("many_lines", 6, TB_H, 1'b0, -1, -1, 32, 1, 1, 1);
    frame_chk("odd_byte", TB_V, TB_H, 1'b1, -1, -1, 32, 1, 0, 1);
    frame_chk("short", 3, TB_H, 1'b0, -1, -1, 24, 1, 1, 1);

    frame_chk("en_drop", TB_V, TB_H, 1'b0, 10, -1, 10, 0, 0, 1);
    i_en = 1'b1;
    repeat (2) @(negedge i_p_clk);
    frame_chk("reen_skip1", TB_V, TB_H, 1'b0, -1, -1, 0, 0, 0, 0);
    frame_chk("reen_skip2", TB_V, TB_H, 1'b0, -1, -1, 0, 0, 0, 0);
    frame_chk("reen_cap", TB_V, TB_H, 1'b0, -1, -1, 32, 1, 0, 1);

    frame_chk("rst_mid", TB_V, TB_H, 1'b0, -1, 12, 12, 0, 0, 1);
    frame_chk("rst_skip1", TB_V, TB_H, 1'b0, -1, -1, 0, 0, 0, 0);
    frame_chk("rst_skip2", TB_V, TB_H, 1'b0, -1, -1, 0, 0, 0, 0);
    frame_chk("rst_cap", TB_V, TB_H, 1'b0, -1, -1, 32, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
